// File: rtl/m_ctrl_fsm.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/mem/wb.
// Decodes IR opcode/funct; drives datapath selects, enables, mem strobes.
module m_ctrl_fsm #(
  parameter bit ILLEGAL_HALT = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Inst,
  input  logic        zero,
  input  logic        overflow,
  input  logic        MIO_ready,
  output logic        IorD,
  output logic        IRWrite,
  output logic [1:0]  RegDst,
  output logic        RegWrite,
  output logic [1:0]  MemtoReg,
  output logic        ALUSrcA,
  output logic [2:0]  ALUSrcB,
  output logic [1:0]  PCSource,
  output logic        PCWrite,
  output logic        PCWriteCond,
  output logic        Branch,
  output logic [3:0]  ALU_operation,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [4:0]  state
);

  typedef enum logic [4:0] {
    S_IF    = 5'd0,
    S_ID    = 5'd1,
    S_MA    = 5'd2,
    S_MR    = 5'd3,
    S_LW_WB = 5'd4,
    S_MW    = 5'd5,
    S_R_EX  = 5'd6,
    S_R_WB  = 5'd7,
    S_BEQ   = 5'd8,
    S_BNE   = 5'd9,
    S_J     = 5'd10,
    S_JAL   = 5'd11,
    S_I_EX  = 5'd12,
    S_I_WB  = 5'd13,
    S_LUI   = 5'd14,
    S_JR    = 5'd15,
    S_HALT  = 5'd16
  } state_t;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_XOR = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;

  state_t state_q, state_d, st_dec;

  logic [5:0] opc, fn;
  logic       is_r, r_ok, is_jr, addsub;
  logic       is_lw, is_sw, is_addi, is_slti;
  logic [3:0] r_op;
  logic       unused_inst;

  assign opc         = Inst[31:26];
  assign fn          = Inst[5:0];
  assign unused_inst = ^Inst[25:6];

  assign is_r    = (opc == 6'b000000);
  assign is_lw   = (opc == 6'b100011);
  assign is_sw   = (opc == 6'b101011);
  assign is_addi = (opc == 6'b001000);
  assign is_slti = (opc == 6'b001010);
  assign is_jr   = (fn == 6'b001000);
  assign addsub  = (fn == 6'b100000) ||
                   (fn == 6'b100010);

  always_comb begin
    r_ok = 1'b1;
    r_op = OP_ADD;
    case (fn)
      6'b100000: r_op = OP_ADD;
      6'b100010: r_op = OP_SUB;
      6'b100100: r_op = OP_AND;
      6'b100101: r_op = OP_OR;
      6'b100110: r_op = OP_XOR;
      6'b100111: r_op = OP_NOR;
      6'b101010: r_op = OP_SLT;
      default:   r_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d = S_IF;
    case (state_q)
      S_IF: state_d = MIO_ready ? S_ID : S_IF;
      S_ID: begin
        unique case (1'b1)
          is_r && r_ok:         state_d = S_R_EX;
          is_r && is_jr:        state_d = S_JR;
          is_lw || is_sw:       state_d = S_MA;
          opc == 6'b000100:     state_d = S_BEQ;
          opc == 6'b000101:     state_d = S_BNE;
          opc == 6'b000010:     state_d = S_J;
          opc == 6'b000011:     state_d = S_JAL;
          is_addi || is_slti:   state_d = S_I_EX;
          opc == 6'b001111:     state_d = S_LUI;
          default:
            state_d = ILLEGAL_HALT ? S_HALT : S_IF;
        endcase
      end
      S_MA:   state_d = is_lw ? S_MR : S_MW;
      S_MR:   state_d = MIO_ready ? S_LW_WB : S_MR;
      S_MW:   state_d = MIO_ready ? S_IF : S_MW;
      S_R_EX: state_d = S_R_WB;
      S_I_EX: state_d = S_I_WB;
      S_HALT: state_d = S_HALT;
      default: state_d = S_IF;
    endcase
    if (reset) state_d = S_IF;
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  assign state  = state_q;
  // Under reset the outputs show IF selects with every enable off.
  assign st_dec = reset ? S_IF : state_q;

  always_comb begin
    IorD          = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'b00;
    RegWrite      = 1'b0;
    MemtoReg      = 2'b00;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 3'b000;
    PCSource      = 2'b00;
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    Branch        = 1'b0;
    ALU_operation = OP_AND;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    case (st_dec)
      S_IF: begin
        MemRead       = 1'b1;
        ALUSrcB       = 3'b001;
        ALU_operation = OP_ADD;
        IRWrite       = MIO_ready;
        PCWrite       = MIO_ready;
      end
      S_ID: begin
        ALUSrcA       = 1'b1;
        ALUSrcB       = 3'b011;
        ALU_operation = OP_ADD;
      end
      S_MA: begin
        ALUSrcB       = 3'b010;
        ALU_operation = OP_ADD;
      end
      S_MR: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_LW_WB: begin
        MemtoReg = 2'b01;
        RegWrite = 1'b1;
      end
      S_MW: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
      end
      S_R_EX: ALU_operation = r_op;
      S_R_WB: begin
        ALU_operation = r_op;
        RegDst        = 2'b01;
        RegWrite      = ~(addsub & overflow);
      end
      S_BEQ: begin
        ALU_operation = OP_SUB;
        PCSource      = 2'b01;
        PCWriteCond   = 1'b1;
        Branch        = 1'b1;
      end
      S_BNE: begin
        ALU_operation = OP_SUB;
        PCSource      = 2'b01;
        PCWrite       = ~zero;
      end
      S_J: begin
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_JAL: begin
        RegDst   = 2'b10;
        MemtoReg = 2'b10;
        RegWrite = 1'b1;
        PCSource = 2'b10;
        PCWrite  = 1'b1;
      end
      S_I_EX: begin
        ALUSrcB       = 3'b010;
        ALU_operation = is_slti ? OP_SLT : OP_ADD;
      end
      S_I_WB: begin
        ALUSrcB       = 3'b010;
        ALU_operation = is_slti ? OP_SLT : OP_ADD;
        RegWrite      = ~(is_addi & overflow);
      end
      S_LUI: begin
        MemtoReg = 2'b11;
        RegWrite = 1'b1;
      end
      S_JR: begin
        ALUSrcB       = 3'b101;
        ALU_operation = OP_ADD;
        PCWrite       = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      IRWrite     = 1'b0;
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_m_ctrl_fsm.sv
// Testbench for m_ctrl_fsm: directed + random instructions vs a model.
// Two instances cover both ILLEGAL_HALT settings on shared stimulus.
module tb_m_ctrl_fsm;

  typedef struct packed {
    logic       iord;
    logic       irw;
    logic [1:0] rdst;
    logic       rw;
    logic [1:0] m2r;
    logic       srca;
    logic [2:0] srcb;
    logic [1:0] pcs;
    logic       pcw;
    logic       pcwc;
    logic       br;
    logic [3:0] aluop;
    logic       mr;
    logic       mw;
  } ctl_t;

  localparam logic [3:0] ADD = 4'b0010;
  localparam logic [3:0] SUB = 4'b0110;
  localparam logic [3:0] SLT = 4'b0111;

  logic clk = 1'b0;
  logic reset, zero, overflow, MIO_ready;
  logic [31:0] Inst;

  logic IorD, IRWrite, RegWrite, ALUSrcA;
  logic PCWrite, PCWriteCond, Branch;
  logic MemRead, MemWrite;
  logic [1:0] RegDst, MemtoReg, PCSource;
  logic [2:0] ALUSrcB;
  logic [3:0] ALU_operation;
  logic [4:0] state;

  logic h_IorD, h_IRWrite, h_RegWrite, h_ALUSrcA;
  logic h_PCWrite, h_PCWriteCond, h_Branch;
  logic h_MemRead, h_MemWrite;
  logic [1:0] h_RegDst, h_MemtoReg, h_PCSource;
  logic [2:0] h_ALUSrcB;
  logic [3:0] h_ALU_operation;
  logic [4:0] h_state;

  ctl_t c0, hc;
  int tests = 0;
  int fails = 0;
  int mw;

  logic [5:0] rfn [8] = '{6'h20, 6'h22, 6'h24, 6'h25,
                          6'h26, 6'h27, 6'h2a, 6'h08};
  logic [5:0] iop [9] = '{6'h23, 6'h2b, 6'h04, 6'h05, 6'h02,
                          6'h03, 6'h08, 6'h0a, 6'h0f};

  always #5 clk = ~clk;

  m_ctrl_fsm #(.ILLEGAL_HALT(1'b0)) u0 (
    .clk(clk), .reset(reset), .Inst(Inst),
    .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready),
    .IorD(IorD), .IRWrite(IRWrite), .RegDst(RegDst),
    .RegWrite(RegWrite), .MemtoReg(MemtoReg),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .PCWrite(PCWrite),
    .PCWriteCond(PCWriteCond), .Branch(Branch),
    .ALU_operation(ALU_operation),
    .MemRead(MemRead), .MemWrite(MemWrite),
    .state(state)
  );

  m_ctrl_fsm #(.ILLEGAL_HALT(1'b1)) u1 (
    .clk(clk), .reset(reset), .Inst(Inst),
    .zero(zero), .overflow(overflow),
    .MIO_ready(MIO_ready),
    .IorD(h_IorD), .IRWrite(h_IRWrite),
    .RegDst(h_RegDst), .RegWrite(h_RegWrite),
    .MemtoReg(h_MemtoReg), .ALUSrcA(h_ALUSrcA),
    .ALUSrcB(h_ALUSrcB), .PCSource(h_PCSource),
    .PCWrite(h_PCWrite), .PCWriteCond(h_PCWriteCond),
    .Branch(h_Branch), .ALU_operation(h_ALU_operation),
    .MemRead(h_MemRead), .MemWrite(h_MemWrite),
    .state(h_state)
  );

  assign c0 = {IorD, IRWrite, RegDst, RegWrite, MemtoReg,
               ALUSrcA, ALUSrcB, PCSource, PCWrite,
               PCWriteCond, Branch, ALU_operation,
               MemRead, MemWrite};
  assign hc = {h_IorD, h_IRWrite, h_RegDst, h_RegWrite,
               h_MemtoReg, h_ALUSrcA, h_ALUSrcB,
               h_PCSource, h_PCWrite, h_PCWriteCond,
               h_Branch, h_ALU_operation,
               h_MemRead, h_MemWrite};

  // Expected controls for a step of an instruction, from the ISA rules.
  function automatic ctl_t model(input int st,
                                 input logic [31:0] ins,
                                 input logic mio,
                                 input logic z,
                                 input logic ov);
    ctl_t c;
    logic [5:0] op, fn;
    logic [3:0] rop;
    logic trap;
    c = '0;
    op = ins[31:26];
    fn = ins[5:0];
    case (fn)
      6'h20: rop = ADD;
      6'h22: rop = SUB;
      6'h24: rop = 4'b0000;
      6'h25: rop = 4'b0001;
      6'h26: rop = 4'b0011;
      6'h27: rop = 4'b1100;
      6'h2a: rop = SLT;
      default: rop = 4'bxxxx;
    endcase
    trap = ov && (fn == 6'h20 || fn == 6'h22);
    case (st)
      0: begin
        c.mr = 1; c.srcb = 3'b001; c.aluop = ADD;
        c.irw = mio; c.pcw = mio;
      end
      1: begin c.srca = 1; c.srcb = 3'b011; c.aluop = ADD; end
      2: begin c.srcb = 3'b010; c.aluop = ADD; end
      3: begin c.mr = 1; c.iord = 1; end
      4: begin c.m2r = 2'b01; c.rw = 1; end
      5: begin c.mw = 1; c.iord = 1; end
      6: c.aluop = rop;
      7: begin c.aluop = rop; c.rdst = 2'b01; c.rw = !trap; end
      8: begin
        c.aluop = SUB; c.pcs = 2'b01; c.pcwc = 1; c.br = 1;
      end
      9: begin c.aluop = SUB; c.pcs = 2'b01; c.pcw = !z; end
      10: begin c.pcs = 2'b10; c.pcw = 1; end
      11: begin
        c.rdst = 2'b10; c.m2r = 2'b10; c.rw = 1;
        c.pcs = 2'b10; c.pcw = 1;
      end
      12, 13: begin
        c.srcb = 3'b010;
        c.aluop = (op == 6'h0a) ? SLT : ADD;
        if (st == 13) c.rw = !(op == 6'h08 && ov);
      end
      14: begin c.m2r = 2'b11; c.rw = 1; end
      15: begin c.srcb = 3'b101; c.aluop = ADD; c.pcw = 1; end
      default: ;
    endcase
    return c;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic mio, input int st);
    ctl_t e;
    @(negedge clk);
    MIO_ready = mio;
    #2;
    e = model(st, Inst, mio, zero, overflow);
    chk($sformatf("state(exp %0d)", st), 32'(state), st);
    chk($sformatf("h_state(exp %0d)", st), 32'(h_state), st);
    chk($sformatf("ctl@%0d ins=%h", st, Inst), 32'(c0), 32'(e));
    chk($sformatf("h_ctl@%0d ins=%h", st, Inst), 32'(hc), 32'(e));
  endtask

  task automatic rst_chk(input int st);
    ctl_t e;
    e = model(0, Inst, MIO_ready, zero, overflow);
    e.irw = 0;
    e.pcw = 0;
    chk("rst_state", 32'(state), st);
    chk("rst_h_state", 32'(h_state), st);
    chk("rst_ctl", 32'(c0), 32'(e));
  endtask

  task automatic run_inst(input logic [31:0] ins,
                          input logic z, input logic ov,
                          input int nst, input bit rnd,
                          output int mw_n);
    int path[$];
    logic [5:0] op, fn;
    op = ins[31:26];
    fn = ins[5:0];
    path = '{0, 1};
    case (op)
      6'h00: begin
        if (fn == 6'h08) path.push_back(15);
        else begin path.push_back(6); path.push_back(7); end
      end
      6'h23: begin
        path.push_back(2); path.push_back(3); path.push_back(4);
      end
      6'h2b: begin path.push_back(2); path.push_back(5); end
      6'h04: path.push_back(8);
      6'h05: path.push_back(9);
      6'h02: path.push_back(10);
      6'h03: path.push_back(11);
      6'h08, 6'h0a: begin path.push_back(12); path.push_back(13); end
      6'h0f: path.push_back(14);
      default: ;
    endcase
    Inst = ins;
    zero = z;
    overflow = ov;
    mw_n = 0;
    foreach (path[i]) begin
      int ns;
      bit mem;
      mem = (path[i] == 0 || path[i] == 3 || path[i] == 5);
      ns = 0;
      if (mem) ns = rnd ? int'($urandom_range(0, 2)) : nst;
      for (int k = 0; k <= ns; k++) begin
        logic mio;
        mio = mem ? (k == ns) : 1'($urandom);
        cyc(mio, path[i]);
        if (MemWrite) mw_n++;
      end
    end
  endtask

  task automatic illegal(input logic [31:0] ins);
    Inst = ins;
    zero = 0;
    overflow = 0;
    cyc(1, 0);
    cyc(1, 1);
    @(negedge clk);
    MIO_ready = 0;
    #2;
    chk("ill_u0_state", 32'(state), 0);
    chk("ill_u1_state", 32'(h_state), 16);
    repeat (3) begin
      @(negedge clk);
      MIO_ready = 1;
      #2;
      chk("halt_state", 32'(h_state), 16);
      chk("halt_ctl", 32'(hc), 0);
    end
    @(negedge clk);
    reset = 1;
    MIO_ready = 0;
    @(negedge clk);
    #2;
    rst_chk(0);
    reset = 0;
  endtask

  initial begin
    reset = 1;
    Inst = 32'h0;
    zero = 0;
    overflow = 0;
    MIO_ready = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2;
    rst_chk(0);
    @(negedge clk);
    reset = 0;
    MIO_ready = 0;

    run_inst(32'h8C010004, 0, 0, 0, 0, mw);
    run_inst(32'hAC010004, 0, 0, 3, 0, mw);
    chk("sw_memwrite_cycles", mw, 4);
    run_inst(32'h10220003, 1, 0, 0, 0, mw);
    run_inst(32'h14220003, 1, 0, 0, 0, mw);
    run_inst(32'h14220003, 0, 0, 0, 0, mw);
    run_inst(32'h00221820, 0, 1, 0, 0, mw);
    run_inst(32'h00221820, 0, 0, 0, 0, mw);
    run_inst(32'h00221822, 0, 1, 0, 0, mw);
    run_inst(32'h00221824, 0, 1, 0, 0, mw);
    run_inst(32'h0022182A, 0, 1, 0, 0, mw);
    run_inst(32'h20210005, 0, 1, 0, 0, mw);
    run_inst(32'h28210005, 0, 1, 0, 0, mw);
    run_inst(32'h3C011234, 0, 0, 0, 0, mw);
    run_inst(32'h08000010, 0, 0, 0, 0, mw);
    run_inst(32'h0C000010, 0, 0, 0, 0, mw);
    run_inst(32'h03E00008, 0, 0, 0, 0, mw);

    for (int n = 0; n < 150; n++) begin
      logic [31:0] ins;
      int kind;
      kind = $urandom_range(0, 16);
      ins = $urandom;
      if (kind < 8) begin
        ins[31:26] = 6'h00;
        ins[5:0] = rfn[kind];
      end else begin
        ins[31:26] = iop[kind-8];
      end
      run_inst(ins, 1'($urandom), 1'($urandom), 0, 1, mw);
    end

    Inst = 32'h8C010004;
    zero = 0;
    overflow = 0;
    cyc(1, 0);
    cyc(1, 1);
    cyc(1, 2);
    cyc(0, 3);
    @(negedge clk);
    reset = 1;
    MIO_ready = 1;
    #2;
    rst_chk(3);
    @(negedge clk);
    #2;
    rst_chk(0);
    @(negedge clk);
    reset = 0;
    MIO_ready = 0;

    illegal(32'hFC000000);
    illegal(32'h0000003F);
    run_inst(32'h8C010004, 0, 0, 1, 0, mw);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
